uart_cmd_parser: RTL and testbench

// - Sits directly downstream of the UART receiver in the serial debug unit; consumes received bytes (d_rx/vld_rx/rdy_rx).
// - Assembles ASCII command lines ("W 1000 DEADBEEF\r") into one decoded command: opcode, address and data.
// - Presents the decoded command to the debug controller over a valid/ready handshake.
// - Flags malformed lines with a one-cycle error pulse.

---
 rtl/dbg_cmd_pkg.sv | 43 ++++
 rtl/hex_nibble_dec.sv | 29 ++
 rtl/uart_cmd_parser.sv | 191 +++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_cmd_pkg.sv
// Shared opcodes, ASCII constants and state encoding for the
// serial debug command parser.
package dbg_cmd_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_R    = 3'd1;
    localparam logic [2:0] OP_W    = 3'd2;
    localparam logic [2:0] OP_D    = 3'd3;
    localparam logic [2:0] OP_G    = 3'd4;
    localparam logic [2:0] OP_S    = 3'd5;
    localparam logic [2:0] OP_B    = 3'd6;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_SP = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP,
        S_ADDR,
        S_DATA,
        S_DISCARD,
        S_CHECK,
        S_ISSUE
    } state_t;

    // Clearing bit 5 folds lower-case letters onto upper-case.
    function automatic logic [2:0] ascii_to_op(input logic [7:0] ch);
        logic [2:0] op;
        op = OP_NONE;
        case (ch & 8'hDF)
            8'h52:   op = OP_R;
            8'h57:   op = OP_W;
            8'h44:   op = OP_D;
            8'h47:   op = OP_G;
            8'h53:   op = OP_S;
            8'h42:   op = OP_B;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/hex_nibble_dec.sv
// ASCII hex digit decoder: flags 0-9/A-F/a-f and returns the
// nibble value.
module hex_nibble_dec (
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nib
);

    always_comb begin
        is_hex = 1'b0;
        nib    = 4'h0;
        unique case (1'b1)
            (ch >= 8'h30 && ch <= 8'h39): begin
                is_hex = 1'b1;
                nib    = ch[3:0];
            end
            (ch >= 8'h41 && ch <= 8'h46),
            (ch >= 8'h61 && ch <= 8'h66): begin
                is_hex = 1'b1;
                nib    = ch[3:0] + 4'd9;
            end
            default: begin
                is_hex = 1'b0;
                nib    = 4'h0;
            end
        endcase
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles ASCII debug command lines from the UART receiver into
// decoded opcode/address/data commands on a valid/ready handshake.
module uart_cmd_parser
    import dbg_cmd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        d_rx,
    input  logic              vld_rx,
    output logic              rdy_rx,
    output logic [2:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_vld,
    input  logic              cmd_rdy,
    output logic              err
);

    localparam int AMAX = ADDR_W / 4;
    localparam int DMAX = DATA_W / 4;
    localparam int ACW  = $clog2(AMAX + 1);
    localparam int DCW  = $clog2(DMAX + 1);

    state_t            state, state_n;
    logic              vld_q;
    logic [2:0]        op_r, op_n;
    logic [ADDR_W-1:0] addr_r, addr_n;
    logic [DATA_W-1:0] data_r, data_n;
    logic [ACW-1:0]    acnt, acnt_n;
    logic [DCW-1:0]    dcnt, dcnt_n;
    logic              err_n;
    logic              load;
    logic              chk_ok;
    logic              is_hex;
    logic [3:0]        nib;
    logic              strobe;
    logic              take;
    logic              is_sp;
    logic              is_term;
    logic [2:0]        ch_op;

    hex_nibble_dec u_hex (
        .ch     (d_rx),
        .is_hex (is_hex),
        .nib    (nib)
    );

    assign strobe  = vld_rx & ~vld_q;
    assign take    = strobe & rdy_rx;
    assign is_sp   = (d_rx == CH_SP);
    assign is_term = (d_rx == CH_CR) || (d_rx == CH_LF);
    assign ch_op   = ascii_to_op(d_rx);
    assign cmd_vld = (state == S_ISSUE);

    always_comb begin
        chk_ok = 1'b0;
        case (op_r)
            OP_R, OP_B: chk_ok = (acnt != '0) && (dcnt == '0);
            OP_W:       chk_ok = (acnt != '0) && (dcnt != '0);
            OP_D:       chk_ok = (dcnt == '0);
            OP_G, OP_S: chk_ok = (acnt == '0) && (dcnt == '0);
            default:    chk_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        op_n    = op_r;
        addr_n  = addr_r;
        data_n  = data_r;
        acnt_n  = acnt;
        dcnt_n  = dcnt;
        load    = 1'b0;
        err_n   = strobe & ~rdy_rx;
        unique case (state)
            S_IDLE: begin
                if (take && !is_sp && !is_term) begin
                    if (ch_op != OP_NONE) begin
                        op_n    = ch_op;
                        addr_n  = '0;
                        data_n  = '0;
                        acnt_n  = '0;
                        dcnt_n  = '0;
                        state_n = S_OP;
                    end else begin
                        state_n = S_DISCARD;
                    end
                end
            end
            S_OP: begin
                if (take) begin
                    if (is_sp)        state_n = S_ADDR;
                    else if (is_term) state_n = S_CHECK;
                    else              state_n = S_DISCARD;
                end
            end
            S_ADDR: begin
                if (take) begin
                    if (is_hex) begin
                        if (acnt == ACW'(AMAX)) begin
                            state_n = S_DISCARD;
                        end else begin
                            addr_n = {addr_r[ADDR_W-5:0], nib};
                            acnt_n = acnt + ACW'(1);
                        end
                    end else if (is_sp) begin
                        if (acnt != '0) state_n = S_DATA;
                    end else if (is_term) begin
                        state_n = S_CHECK;
                    end else begin
                        state_n = S_DISCARD;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    if (is_hex) begin
                        if (dcnt == DCW'(DMAX)) begin
                            state_n = S_DISCARD;
                        end else begin
                            data_n = {data_r[DATA_W-5:0], nib};
                            dcnt_n = dcnt + DCW'(1);
                        end
                    end else if (is_sp) begin
                        if (dcnt != '0) state_n = S_DISCARD;
                    end else if (is_term) begin
                        state_n = S_CHECK;
                    end else begin
                        state_n = S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if (take && is_term) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            // rdy_rx lags the state, so a byte taken here is ignored.
            S_CHECK: begin
                if (chk_ok) begin
                    load    = 1'b1;
                    state_n = S_ISSUE;
                end else begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cmd_rdy) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            vld_q    <= 1'b0;
            rdy_rx   <= 1'b1;
            err      <= 1'b0;
            op_r     <= OP_NONE;
            addr_r   <= '0;
            data_r   <= '0;
            acnt     <= '0;
            dcnt     <= '0;
            cmd_op   <= OP_NONE;
            cmd_addr <= '0;
            cmd_data <= '0;
        end else begin
            state  <= state_n;
            vld_q  <= vld_rx;
            rdy_rx <= !((state == S_CHECK) || (state == S_ISSUE));
            err    <= err_n;
            op_r   <= op_n;
            addr_r <= addr_n;
            data_r <= data_n;
            acnt   <= acnt_n;
            dcnt   <= dcnt_n;
            if (load) begin
                cmd_op   <= op_r;
                cmd_addr <= addr_r;
                cmd_data <= data_r;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Line-level reference model and randomized stimulus for the
// debug command parser.
module tb_uart_cmd_parser;

    typedef struct {
        int         kind;
        logic [2:0] op;
        logic [31:0] addr;
        logic [31:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d_rx = 8'h00;
    logic        vld_rx = 1'b0;
    logic        rdy_rx;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_vld;
    logic        cmd_rdy = 1'b0;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int cmd_cnt = 0;
    int err0, cmd0;
    bit pending = 0;
    bit rdy_mode = 0;
    bit rdy_force = 1;
    bit prev_vld = 0;
    int exp_kind;
    logic [2:0]  exp_op;
    logic [31:0] exp_addr, exp_data;
    logic [7:0]  cur_line[$];

    uart_cmd_parser dut (
        .clk      (clk),
        .rst      (rst),
        .d_rx     (d_rx),
        .vld_rx   (vld_rx),
        .rdy_rx   (rdy_rx),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_vld  (cmd_vld),
        .cmd_rdy  (cmd_rdy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit hex_val(input logic [7:0] c, output logic [3:0] v);
        v = 4'h0;
        if (c >= "0" && c <= "9") begin v = 4'(c - 8'd48); return 1; end
        if (c >= "A" && c <= "F") begin v = 4'(c - 8'd55); return 1; end
        if (c >= "a" && c <= "f") begin v = 4'(c - 8'd87); return 1; end
        return 0;
    endfunction

    function automatic logic [2:0] letter_op(input logic [7:0] c);
        string ops;
        ops = "RWDGSB";
        for (int j = 0; j < 6; j++)
            if (c == ops[j] || c == ops[j] + 8'd32) return 3'(j + 1);
        return 3'd0;
    endfunction

    // Result of one line: 0 nothing, 1 error, 2 command.
    function automatic res_t model_line();
        res_t r;
        int n, i, ntok;
        int len[2];
        logic [31:0] v[2];
        logic [3:0] nv;
        logic [7:0] c;
        bit intok, bad, ok;
        r.kind = 0; r.op = 0; r.addr = 0; r.data = 0;
        n = cur_line.size() - 1;
        i = 0;
        while (i < n && cur_line[i] == 8'h20) i++;
        if (i >= n) return r;
        r.op = letter_op(cur_line[i]);
        bad = (r.op == 3'd0);
        i++;
        if (i < n && cur_line[i] != 8'h20) bad = 1;
        i++;
        ntok = 0; intok = 0;
        len[0] = 0; len[1] = 0; v[0] = 0; v[1] = 0;
        while (i < n) begin
            c = cur_line[i];
            if (c == 8'h20) begin
                if (intok) begin
                    intok = 0;
                    if (ntok == 2) bad = 1;
                end
            end else if (hex_val(c, nv)) begin
                if (!intok) begin intok = 1; ntok++; end
                if (ntok > 2) bad = 1;
                else begin
                    len[ntok-1]++;
                    if (len[ntok-1] > 8) bad = 1;
                    v[ntok-1] = v[ntok-1] * 16 + 32'(nv);
                end
            end else begin
                bad = 1;
            end
            i++;
        end
        case (r.op)
            3'd1, 3'd6: ok = (ntok == 1);
            3'd2:       ok = (ntok == 2);
            3'd3:       ok = (ntok <= 1);
            3'd4, 3'd5: ok = (ntok == 0);
            default:    ok = 0;
        endcase
        r.kind = (bad || !ok) ? 1 : 2;
        r.addr = v[0];
        r.data = v[1];
        return r;
    endfunction

    task automatic set_line(input string s, input logic [7:0] t);
        cur_line.delete();
        for (int i = 0; i < s.len(); i++) cur_line.push_back(s[i]);
        cur_line.push_back(t);
    endtask

    task automatic pin(input string s, input int kind, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d);
        res_t r;
        set_line(s, 8'h0D);
        r = model_line();
        chk({"model_kind ", s}, 64'(r.kind), 64'(kind));
        if (kind == 2) begin
            chk({"model_op ", s}, 64'(r.op), 64'(op));
            chk({"model_addr ", s}, 64'(r.addr), 64'(a));
            chk({"model_data ", s}, 64'(r.data), 64'(d));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        d_rx   = b;
        vld_rx = 1'b1;
        tick(hold);
        vld_rx = 1'b0;
        tick(1 + gap);
    endtask

    task automatic start_line();
        res_t r;
        r = model_line();
        exp_kind = r.kind;
        exp_op   = r.op;
        exp_addr = r.addr;
        exp_data = r.data;
        pending  = (r.kind == 2);
        err0 = err_cnt;
        cmd0 = cmd_cnt;
        foreach (cur_line[i])
            send_byte(cur_line[i], $urandom_range(1, 3), $urandom_range(0, 2));
    endtask

    task automatic finish_line();
        int i;
        if (exp_kind == 2) begin
            i = 0;
            while (cmd_cnt == cmd0 && i < 400) begin tick(1); i++; end
        end else begin
            tick(6);
        end
        tick(3);
        chk("line_err", 64'(err_cnt - err0), 64'(exp_kind == 1));
        chk("line_cmd", 64'(cmd_cnt - cmd0), 64'(exp_kind == 2));
        pending = 0;
    endtask

    task automatic wait_vld();
        int i;
        i = 0;
        while (cmd_vld !== 1'b1 && i < 100) begin tick(1); i++; end
        chk("wait_cmd_vld", 64'(cmd_vld), 64'd1);
    endtask

    task automatic push_hex(input int n);
        int v;
        for (int i = 0; i < n; i++) begin
            v = $urandom_range(0, 15);
            if (v < 10) cur_line.push_back(8'(48 + v));
            else if ($urandom_range(0, 1) != 0) cur_line.push_back(8'(55 + v));
            else cur_line.push_back(8'(87 + v));
        end
    endtask

    task automatic push_sp();
        cur_line.push_back(8'h20);
        if ($urandom_range(0, 3) == 0) cur_line.push_back(8'h20);
    endtask

    function automatic int pick_len();
        if ($urandom_range(0, 19) == 0) return 9;
        return $urandom_range(0, 8);
    endfunction

    task automatic gen_line();
        string ops;
        int k;
        ops = "RWDGSBrwdgsb";
        cur_line.delete();
        if ($urandom_range(0, 19) == 0) cur_line.push_back(8'h20);
        k = $urandom_range(0, 24);
        if (k == 0)      cur_line.push_back(8'h58);
        else if (k == 1) cur_line.push_back(8'h37);
        else             cur_line.push_back(ops[$urandom_range(0, 11)]);
        if ($urandom_range(0, 5) != 0) begin
            push_sp();
            push_hex(pick_len());
            if ($urandom_range(0, 2) != 0) begin
                push_sp();
                push_hex(pick_len());
            end
            if ($urandom_range(0, 9) == 0) cur_line.push_back(8'h20);
            if ($urandom_range(0, 19) == 0) cur_line.push_back(8'h5A);
        end
        cur_line.push_back(($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
    endtask

    // Per-cycle output checker; cmd_rdy is chosen first so a counted
    // handshake is the one the next edge really sees.
    initial begin
        forever begin
            @(negedge clk);
            cmd_rdy = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
            if (err === 1'b1) err_cnt++;
            if (cmd_vld === 1'b1 && !prev_vld) begin
                n_cmp++;
                if (err === 1'b1) begin
                    n_bad++;
                    $display("FAIL err_at_vld_rise: err=%0b want 0", err);
                end
            end
            if (cmd_vld === 1'b1) begin
                n_cmp++;
                if (!pending || cmd_op !== exp_op || cmd_addr !== exp_addr ||
                    cmd_data !== exp_data) begin
                    n_bad++;
                    $display("FAIL cmd_out: got op=%0d addr=%h data=%h want pending=%0d op=%0d addr=%h data=%h",
                             cmd_op, cmd_addr, cmd_data, pending, exp_op, exp_addr, exp_data);
                end
                if (cmd_rdy) begin
                    pending = 0;
                    cmd_cnt++;
                end
            end
            prev_vld = (cmd_vld === 1'b1);
        end
    end

    initial begin
        int e0;
        tick(3);
        chk("rst_rdy_rx", 64'(rdy_rx), 64'd1);
        chk("rst_cmd_vld", 64'(cmd_vld), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cmd_op", 64'(cmd_op), 64'd0);
        chk("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        chk("rst_cmd_data", 64'(cmd_data), 64'd0);
        rst = 1'b0;
        tick(2);

        pin("R 1A", 2, 3'd1, 32'h1A, 32'h0);
        pin("w  00001000 deadbeef", 2, 3'd2, 32'h1000, 32'hDEADBEEF);
        pin("R 123456789", 1, 0, 0, 0);
        pin("X 10", 1, 0, 0, 0);
        pin("W 10", 1, 0, 0, 0);
        pin("  ", 0, 0, 0, 0);
        pin("G", 2, 3'd4, 0, 0);
        pin("S", 2, 3'd5, 0, 0);
        pin("D 5", 2, 3'd3, 32'h5, 0);
        pin("B", 1, 0, 0, 0);
        pin("W 1 2 ", 1, 0, 0, 0);

        // Latency and single-cycle valid with cmd_rdy held high.
        rdy_force = 1;
        pending = 1; exp_op = 3'd1; exp_addr = 32'h1A; exp_data = 0;
        e0 = err_cnt;
        send_byte("R", 1, 0);
        send_byte(" ", 1, 0);
        send_byte("1", 1, 0);
        send_byte("A", 1, 0);
        d_rx = 8'h0D;
        vld_rx = 1'b1;
        tick(1);
        chk("lat_vld_p1", 64'(cmd_vld), 64'd0);
        vld_rx = 1'b0;
        tick(1);
        chk("lat_vld_p2", 64'(cmd_vld), 64'd1);
        chk("lat_op", 64'(cmd_op), 64'd1);
        chk("lat_addr", 64'(cmd_addr), 64'h1A);
        chk("lat_data", 64'(cmd_data), 64'd0);
        tick(1);
        chk("lat_vld_p3", 64'(cmd_vld), 64'd0);
        tick(3);
        chk("lat_err", 64'(err_cnt - e0), 64'd0);

        // Held command with cmd_rdy low.
        rdy_force = 0;
        set_line("w  00001000 deadbeef", 8'h0A);
        start_line();
        wait_vld();
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("hold_vld", 64'(cmd_vld), 64'd1);
            chk("hold_op", 64'(cmd_op), 64'd2);
            chk("hold_addr", 64'(cmd_addr), 64'h1000);
            chk("hold_data", 64'(cmd_data), 64'hDEADBEEF);
        end
        rdy_force = 1;
        finish_line();

        set_line("R 123456789", 8'h0D); start_line(); finish_line();
        set_line("G", 8'h0D);           start_line(); finish_line();
        set_line("X 10", 8'h0D);        start_line(); finish_line();
        set_line("W 10", 8'h0D);        start_line(); finish_line();
        set_line("", 8'h0D);            start_line(); finish_line();
        set_line("", 8'h0D);            start_line(); finish_line();
        set_line("  ", 8'h0D);          start_line(); finish_line();

        // Level-held valid must give exactly one strobe.
        e0 = err_cnt;
        d_rx = "G";
        vld_rx = 1'b1;
        tick(300);
        vld_rx = 1'b0;
        tick(2);
        exp_kind = 2; exp_op = 3'd4; exp_addr = 0; exp_data = 0;
        pending = 1;
        err0 = e0;
        cmd0 = cmd_cnt;
        send_byte(8'h0D, 1, 0);
        finish_line();

        // Byte arriving while a command waits.
        rdy_force = 0;
        set_line("D 5", 8'h0D);
        start_line();
        wait_vld();
        e0 = err_cnt;
        send_byte("A", 1, 0);
        tick(2);
        chk("issue_drop_err", 64'(err_cnt - e0), 64'd1);
        chk("issue_drop_vld", 64'(cmd_vld), 64'd1);
        chk("issue_drop_op", 64'(cmd_op), 64'd3);
        chk("issue_drop_addr", 64'(cmd_addr), 64'h5);
        err0 = err_cnt;
        rdy_force = 1;
        finish_line();

        // Reset mid-line.
        e0 = err_cnt;
        send_byte("W", 1, 0);
        send_byte(" ", 1, 0);
        send_byte("1", 1, 0);
        send_byte("0", 1, 0);
        send_byte(" ", 1, 0);
        rst = 1'b1;
        tick(1);
        chk("rstmid_vld", 64'(cmd_vld), 64'd0);
        chk("rstmid_err", 64'(err), 64'd0);
        chk("rstmid_rdy", 64'(rdy_rx), 64'd1);
        tick(1);
        rst = 1'b0;
        tick(1);
        set_line("S", 8'h0D); start_line(); finish_line();
        chk("rstmid_no_err", 64'(err_cnt - e0), 64'd0);

        // Reset while a command is presented.
        e0 = err_cnt;
        rdy_force = 0;
        set_line("G", 8'h0D);
        start_line();
        wait_vld();
        rst = 1'b1;
        tick(1);
        chk("rstiss_vld", 64'(cmd_vld), 64'd0);
        chk("rstiss_err", 64'(err), 64'd0);
        pending = 0;
        rst = 1'b0;
        rdy_force = 1;
        tick(3);
        chk("rstiss_no_err", 64'(err_cnt - e0), 64'd0);

        rdy_mode = 1;
        repeat (150) begin
            gen_line();
            start_line();
            finish_line();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
